spike_count_decoder: RTL and testbench
======================================

SPIKE_COUNT_DECODER -- requirements
Module: spike_count_decoder

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10: width of the spike_in bus and number of output classes.
REQ-002 SHALL have parameter COUNT_BITS, default 8: width of each per-class spike counter.
REQ-003 SHALL have parameter WINDOW_BITS, default 8: width of window_len.
REQ-004 SHALL have port clk  input  1: single clock, all logic on the rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port ce  input  1: network step enable, the same strobe that advances the neuron layers.
REQ-007 SHALL have port start  input  1: begin a classification window; sampled only in IDLE.
REQ-008 SHALL have port window_len  input  WINDOW_BITS: number of ce steps to accumulate, latched on an accepted start.
REQ-009 SHALL have port spike_in  input  NUM_CLASSES: final-layer spike vector, one bit per class.
REQ-010 SHALL have port result_ready  input  1: consumer accepts the result.
REQ-011 SHALL have port busy  output  1: high in ACCUM and SCAN.
REQ-012 SHALL have port result_valid  output  1: high in HOLD.
REQ-013 SHALL have port result_class  output  $clog2(NUM_CLASSES): winning class index.
REQ-014 SHALL have port result_count  output  COUNT_BITS: spike count of the winning class.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM, SCAN and HOLD.
REQ-016 IDLE with start=1: clear all counters, latch window_len, clear the step counter, and enter ACCUM; if the latched window_len is 0, enter SCAN directly instead.
REQ-017 ACCUM with ce=1: each counter[i] += spike_in[i], saturating at 2**COUNT_BITS-1 (no wrap), and the step counter increments.
REQ-018 ACCUM with ce=0: counters and the step counter hold.
REQ-019 ACCUM: the cycle with ce=1 and step counter equal to window_len-1 SHALL count its spikes and then move to SCAN.
REQ-020 SCAN: examine one class per cycle, index 0 first through NUM_CLASSES-1, for exactly NUM_CLASSES cycles, then enter HOLD.
REQ-021 Argmax SHALL use strict greater-than, so ties resolve to the lowest index; all-zero counts give class 0 with count 0.
REQ-022 Latency: start accepted at cycle T; result_valid rises at T+1+W+NUM_CLASSES, where W is the number of cycles ACCUM takes to see window_len ce strobes; for window_len=0, it rises at T+1+NUM_CLASSES.
REQ-023 HOLD: result_class, result_count and result_valid remain stable until result_ready=1; on that handshake cycle the next state is IDLE and result_valid falls.
REQ-024 start SHALL be ignored outside IDLE, including in a HOLD cycle with result_ready=1; ce and spike_in SHALL be ignored outside ACCUM.
REQ-025 result_class and result_count SHALL keep their last value in IDLE, ACCUM and SCAN.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE from any state, aborting any window or scan in progress.
REQ-027 Reset values: busy=0, result_valid=0, result_class=0, result_count=0, all counters=0, step counter=0.
REQ-028 rst SHALL take priority over start, ce and result_ready in the same cycle.

Configuration
REQ-029 With macro SPIKE_DECODER_MARGIN_EN defined, SHALL add output result_margin (COUNT_BITS wide): winning count minus highest other count.
REQ-030 result_margin SHALL come from a second-best tracker in SCAN, be 0 on ties, reset to 0, and be stable in HOLD.
REQ-031 Without SPIKE_DECODER_MARGIN_EN, the port and tracker SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Bench: window_len=5, ce=1 always, spike_in=10'b0000001000 every cycle -> result_class=3, result_count=5, result_valid at T+16; with MARGIN_EN, result_margin=5.
REQ-033 Bench: window_len=200, class 7 spikes every cycle, COUNT_BITS=4 -> result_count=15 (saturated), result_class=7.
REQ-034 Bench: classes 2 and 6 each spike 4 times, others 0 -> result_class=2, result_count=4; with MARGIN_EN, result_margin=0.
REQ-035 Bench: window_len=4, ce toggling 1,0,1,0... -> ACCUM lasts 7 cycles, and spikes presented on ce=0 cycles are not counted.
REQ-036 Bench: result_ready held 0 for 20 cycles and start pulsed during HOLD -> result outputs stable and start ignored; result_ready=1 -> IDLE on the next cycle.
REQ-037 Bench: rst=1 mid-ACCUM and mid-SCAN -> next cycle busy=0, result_valid=0, result_class=0; a following start with window_len=0 -> result_class=0, result_count=0 after NUM_CLASSES+1 cycles.

Source files
------------

// File: rtl/spike_count_decoder.sv
// Spike-count readout for a spiking classifier: accumulates per-class spikes over a window of ce steps, then scans for the argmax.
// Optional macro SPIKE_DECODER_MARGIN_EN adds result_margin (winner minus runner-up count).
module spike_count_decoder #(
    parameter int NUM_CLASSES = 10,
    parameter int COUNT_BITS  = 8,
    parameter int WINDOW_BITS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce,
    input  logic                           start,
    input  logic [WINDOW_BITS-1:0]         window_len,
    input  logic [NUM_CLASSES-1:0]         spike_in,
    input  logic                           result_ready,
    output logic                           busy,
    output logic                           result_valid,
    output logic [$clog2(NUM_CLASSES)-1:0] result_class,
    output logic [COUNT_BITS-1:0]          result_count
`ifdef SPIKE_DECODER_MARGIN_EN
    ,
    output logic [COUNT_BITS-1:0]          result_margin
`endif
);
    localparam int IDX_W = $clog2(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, SCAN, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [COUNT_BITS-1:0]   cnt_q [NUM_CLASSES];
    logic [COUNT_BITS-1:0]   cnt_d [NUM_CLASSES];
    logic [WINDOW_BITS-1:0]  step_q, step_d, step_inc;
    logic [WINDOW_BITS-1:0]  win_q, win_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        best_cls_q, best_cls_d, cand_cls;
    logic [COUNT_BITS-1:0]   best_cnt_q, best_cnt_d, cand_cnt, scan_cnt;
    logic [IDX_W-1:0]        res_class_q, res_class_d;
    logic [COUNT_BITS-1:0]   res_count_q, res_count_d;
`ifdef SPIKE_DECODER_MARGIN_EN
    logic [COUNT_BITS-1:0]   second_q, second_d, cand_sec;
    logic [COUNT_BITS-1:0]   res_margin_q, res_margin_d;
`endif

    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] c,
                                                      input logic inc);
        if (!inc || c == CNT_MAX) return c;
        return c + 1'b1;
    endfunction

    assign step_inc = step_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            win_q       <= '0;
            idx_q       <= '0;
            best_cls_q  <= '0;
            best_cnt_q  <= '0;
            res_class_q <= '0;
            res_count_q <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
`ifdef SPIKE_DECODER_MARGIN_EN
            second_q     <= '0;
            res_margin_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            win_q       <= win_d;
            idx_q       <= idx_d;
            best_cls_q  <= best_cls_d;
            best_cnt_q  <= best_cnt_d;
            res_class_q <= res_class_d;
            res_count_q <= res_count_d;
            for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= cnt_d[i];
`ifdef SPIKE_DECODER_MARGIN_EN
            second_q     <= second_d;
            res_margin_q <= res_margin_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (window_len == '0) ? SCAN : ACCUM;
            ACCUM:   if (ce && step_inc == win_q) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = HOLD;
            HOLD:    if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == ACCUM) || (state_q == SCAN);
        result_valid = (state_q == HOLD);
        result_class = res_class_q;
        result_count = res_count_q;
`ifdef SPIKE_DECODER_MARGIN_EN
        result_margin = res_margin_q;
`endif
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        scan_cnt = cnt_q[idx_q];
        cand_cls = best_cls_q;
        cand_cnt = best_cnt_q;
`ifdef SPIKE_DECODER_MARGIN_EN
        cand_sec = second_q;
`endif
        if (scan_cnt > best_cnt_q) begin
            cand_cls = idx_q;
            cand_cnt = scan_cnt;
`ifdef SPIKE_DECODER_MARGIN_EN
            cand_sec = best_cnt_q;
`endif
        end
`ifdef SPIKE_DECODER_MARGIN_EN
        else if (scan_cnt > second_q) begin
            cand_sec = scan_cnt;
        end
`endif
    end

    always_comb begin
        cnt_d       = cnt_q;
        step_d      = step_q;
        win_d       = win_q;
        idx_d       = idx_q;
        best_cls_d  = best_cls_q;
        best_cnt_d  = best_cnt_q;
        res_class_d = res_class_q;
        res_count_d = res_count_q;
`ifdef SPIKE_DECODER_MARGIN_EN
        second_d     = second_q;
        res_margin_d = res_margin_q;
`endif
        unique case (state_q)
            IDLE: if (start) begin
                for (int i = 0; i < NUM_CLASSES; i++) cnt_d[i] = '0;
                win_d      = window_len;
                step_d     = '0;
                idx_d      = '0;
                best_cls_d = '0;
                best_cnt_d = '0;
`ifdef SPIKE_DECODER_MARGIN_EN
                second_d   = '0;
`endif
            end
            ACCUM: if (ce) begin
                for (int i = 0; i < NUM_CLASSES; i++) cnt_d[i] = sat_inc(cnt_q[i], spike_in[i]);
                step_d = step_inc;
            end
            SCAN: begin
                idx_d      = idx_q + 1'b1;
                best_cls_d = cand_cls;
                best_cnt_d = cand_cnt;
`ifdef SPIKE_DECODER_MARGIN_EN
                second_d   = cand_sec;
`endif
                if (idx_q == LAST_IDX) begin
                    res_class_d = cand_cls;
                    res_count_d = cand_cnt;
`ifdef SPIKE_DECODER_MARGIN_EN
                    res_margin_d = cand_cnt - cand_sec;
`endif
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_spike_count_decoder.sv
// Directed bench for spike_count_decoder: default instance plus a COUNT_BITS=4 instance sharing stimulus.
module tb_spike_count_decoder;
    logic       clk = 1'b0;
    logic       rst, ce, start, result_ready;
    logic [7:0] window_len;
    logic [9:0] spike_in;
    logic       busy, result_valid;
    logic [3:0] result_class;
    logic [7:0] result_count;
    logic       busy_s, valid_s;
    logic [3:0] class_s;
    logic [3:0] count_s;
`ifdef SPIKE_DECODER_MARGIN_EN
    logic [7:0] result_margin;
    logic [3:0] margin_s;
`endif
    int total = 0;
    int bad   = 0;
    int lat;
    logic ok;

    always #5 clk = ~clk;

    spike_count_decoder dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .window_len(window_len),
        .spike_in(spike_in), .result_ready(result_ready), .busy(busy),
        .result_valid(result_valid), .result_class(result_class), .result_count(result_count)
`ifdef SPIKE_DECODER_MARGIN_EN
        , .result_margin(result_margin)
`endif
    );

    spike_count_decoder #(.COUNT_BITS(4)) dut_s (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .window_len(window_len),
        .spike_in(spike_in), .result_ready(result_ready), .busy(busy_s),
        .result_valid(valid_s), .result_class(class_s), .result_count(count_s)
`ifdef SPIKE_DECODER_MARGIN_EN
        , .result_margin(margin_s)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int mode, input int k);
        ce = 1'b1;
        spike_in = '0;
        case (mode)
            0: spike_in = 10'b0000001000;
            1: spike_in = 10'b0010000000;
            2: if (k >= 1 && k <= 4) spike_in = 10'b0001000100;
            3: begin
                ce = k[0];
                spike_in = k[0] ? 10'b0000000010 : 10'b0000100010;
            end
            5: case (k)
                1: spike_in = 10'b1000000001;
                2: spike_in = 10'b1000000000;
                3: spike_in = 10'b1000010000;
                default: ;
            endcase
            default: ;
        endcase
    endtask

    // lat = number of negedges after the start cycle until result_valid is seen
    task automatic run(input int win, input int mode, output int lat_o);
        window_len = win[7:0];
        start = 1'b1;
        drive(mode, 0);
        @(negedge clk);
        start = 1'b0;
        lat_o = -1;
        for (int k = 1; k <= 600; k++) begin
            if (result_valid) begin
                lat_o = k;
                break;
            end
            drive(mode, k);
            @(negedge clk);
        end
        ce = 1'b0;
        spike_in = '0;
    endtask

    task automatic release_result(input string tag);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk({tag, "_valid_low"}, result_valid, 0);
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; start = 1'b0; result_ready = 1'b0;
        window_len = '0; spike_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_class", result_class, 0);
        chk("rst_count", result_count, 0);
`ifdef SPIKE_DECODER_MARGIN_EN
        chk("rst_margin", result_margin, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // single class, window 5
        run(5, 0, lat);
        chk("w5_latency", lat, 16);
        chk("w5_class", result_class, 3);
        chk("w5_count", result_count, 5);
        chk("w5_busy", busy, 0);
        chk("w5_s_count", count_s, 5);
`ifdef SPIKE_DECODER_MARGIN_EN
        chk("w5_margin", result_margin, 5);
`endif

        // long HOLD with a stray start
        ok = 1'b1;
        window_len = 8'd0;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            @(negedge clk);
            if (!(result_valid && !busy && result_class == 4'd3 && result_count == 8'd5)) ok = 1'b0;
        end
        start = 1'b0;
        chk("hold_stable", ok, 1);
        result_ready = 1'b1;
        start = 1'b1;
        window_len = 8'd5;
        @(negedge clk);
        start = 1'b0;
        result_ready = 1'b0;
        chk("hs_valid_low", result_valid, 0);
        chk("hs_busy_low", busy, 0);
        @(negedge clk);
        chk("hs_start_ignored", busy, 0);

        // saturation
        run(200, 1, lat);
        chk("w200_latency", lat, 211);
        chk("w200_class", result_class, 7);
        chk("w200_count", result_count, 200);
        chk("w200_s_class", class_s, 7);
        chk("w200_s_count", count_s, 15);
        release_result("w200");

        // tie between classes 2 and 6
        run(6, 2, lat);
        chk("tie_latency", lat, 17);
        chk("tie_class", result_class, 2);
        chk("tie_count", result_count, 4);
`ifdef SPIKE_DECODER_MARGIN_EN
        chk("tie_margin", result_margin, 0);
`endif
        release_result("tie");

        // ce toggling
        run(4, 3, lat);
        chk("ce_latency", lat, 18);
        chk("ce_class", result_class, 1);
        chk("ce_count", result_count, 4);
`ifdef SPIKE_DECODER_MARGIN_EN
        chk("ce_margin", result_margin, 4);
`endif
        release_result("ce");

        // winner at the last index
        run(3, 5, lat);
        chk("last_latency", lat, 14);
        chk("last_class", result_class, 9);
        chk("last_count", result_count, 3);
`ifdef SPIKE_DECODER_MARGIN_EN
        chk("last_margin", result_margin, 2);
`endif
        release_result("last");

        // reset mid-ACCUM
        window_len = 8'd10;
        start = 1'b1;
        drive(0, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("accum_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ce = 1'b0;
        spike_in = '0;
        chk("rst_accum_busy", busy, 0);
        chk("rst_accum_valid", result_valid, 0);
        chk("rst_accum_class", result_class, 0);
        chk("rst_accum_count", result_count, 0);
        @(negedge clk);
        chk("rst_accum_idle", busy, 0);

        // reset mid-SCAN, with start asserted alongside rst
        run(5, 0, lat);
        chk("pre_scan_class", result_class, 3);
        release_result("pre_scan");
        window_len = 8'd2;
        start = 1'b1;
        drive(0, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("scan_busy", busy, 1);
        chk("scan_valid", result_valid, 0);
        rst = 1'b1;
        start = 1'b1;
        window_len = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        ce = 1'b0;
        spike_in = '0;
        chk("rst_scan_busy", busy, 0);
        chk("rst_scan_valid", result_valid, 0);
        chk("rst_scan_class", result_class, 0);
        @(negedge clk);
        chk("rst_scan_idle", busy, 0);

        // empty window
        run(0, 4, lat);
        chk("w0_latency", lat, 11);
        chk("w0_class", result_class, 0);
        chk("w0_count", result_count, 0);
        release_result("w0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
